mem_access_unit: RTL

Load/store initiator that drives the data_mem port (read/write strobes, 4-bit access code, address, write data) on behalf of the core.
- Accepts one request at a time over a valid/ready handshake and issues the matching data_mem access.
- Splits misaligned halfword/word accesses into sequential byte accesses.
- Assembles and sign/zero-extends load data, then returns a one-cycle completion response.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for data_mem; misaligned half/word accesses become sequential byte accesses.
// Latency: accept -> n access cycles -> 1-cycle response pulse; req_ready stays low until back in IDLE.
module mem_access_unit #(
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        MEMR,
  output logic        MEMW,
  output logic [3:0]  MEM_Ctrl,
  output logic [31:0] addr,
  output logic [31:0] dataW,
  input  logic [31:0] dataR
);

  localparam logic [3:0] CODE_LW  = 4'd2;
  localparam logic [3:0] CODE_LBU = 4'd3;
  localparam logic [3:0] CODE_LHU = 4'd4;
  localparam logic [3:0] CODE_SB  = 4'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q, uns_q, split_q, err_q;
  logic [1:0]  size_q, idx_q, last_idx;
  logic [31:0] addr_q, wdata_q, asm_q, rdata_q;
  logic [31:0] asm_nxt, load_result;
  logic [3:0]  direct_code;
  logic [7:0]  wbyte;
  logic        accept, req_misaligned, req_illegal, last_access;

  assign accept         = req_valid && req_ready;
  assign req_misaligned = (req_size == 2'd1 && req_addr[0]) ||
                          (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign req_illegal    = (req_size == 2'd3) || (req_misaligned && ALLOW_MISALIGNED == 0);

  assign last_idx    = split_q ? ((size_q == 2'd2) ? 2'd3 : 2'd1) : 2'd0;
  assign last_access = (idx_q == last_idx);
  assign wbyte       = wdata_q[{idx_q, 3'b000} +: 8];

  // Split loads gather bytes little-endian; the final byte is merged in before extension.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{idx_q, 3'b000} +: 8] = dataR[7:0];
  end

  always_comb begin
    load_result = dataR;
    if (split_q) begin
      if (size_q == 2'd1) begin
        load_result = uns_q ? {16'h0000, asm_nxt[15:0]} : {{16{asm_nxt[15]}}, asm_nxt[15:0]};
      end else begin
        load_result = asm_nxt;
      end
    end
  end

  always_comb begin
    direct_code = 4'd0;
    if (we_q) begin
      direct_code = CODE_SB + {2'b00, size_q};
    end else begin
      case (size_q)
        2'd0:    direct_code = uns_q ? CODE_LBU : 4'd0;
        2'd1:    direct_code = uns_q ? CODE_LHU : 4'd1;
        default: direct_code = CODE_LW;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP) && !rst;
    rsp_err   = (state == RESP) && !rst && err_q;
    rsp_rdata = rdata_q;
    MEMR      = 1'b0;
    MEMW      = 1'b0;
    MEM_Ctrl  = 4'd0;
    addr      = 32'h0;
    dataW     = 32'h0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        MEMR     = !we_q && !rst;
        MEMW     = we_q && !rst;
        MEM_Ctrl = split_q ? (we_q ? CODE_SB : CODE_LBU) : direct_code;
        addr     = addr_q + {30'd0, idx_q};
        dataW    = split_q ? {24'h0, wbyte} : wdata_q;
        if (last_access) state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      idx_q   <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            split_q <= req_misaligned;
            err_q   <= req_illegal;
            idx_q   <= 2'd0;
            asm_q   <= 32'h0;
            if (req_illegal) rdata_q <= 32'h0;
          end
        end
        ACCESS: begin
          idx_q <= idx_q + 2'd1;
          if (!we_q) asm_q <= asm_nxt;
          if (last_access) rdata_q <= we_q ? 32'h0 : load_result;
        end
        default: ;
      endcase
    end
  end

endmodule
